// File: rtl/spi_mnrch_gen_if.sv
// spi_mnrch_gen_if: command-side handshake and SPI pins of the monarch master.
// master = the SPI master itself, slave = command logic plus external device.
interface spi_mnrch_gen_if #(
    parameter int DATA_W = 16,
    parameter int NUM_SS = 2,
    parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
    logic              snd;
    logic [DATA_W-1:0] cmd;
    logic [SEL_W-1:0]  ss_sel;
    logic [1:0]        mode;
    logic              MISO;
    logic              SCLK;
    logic              MOSI;
    logic [NUM_SS-1:0] SS_n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] resp;

    modport master (
        input  snd, cmd, ss_sel, mode, MISO,
        output SCLK, MOSI, SS_n, busy, done, resp
    );

    modport slave (
        output snd, cmd, ss_sel, mode, MISO,
        input  SCLK, MOSI, SS_n, busy, done, resp
    );
endinterface

// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen: parametrised full-duplex SPI master, one word per snd.
// Word width, SCLK divider, slave count and per-transfer CPOL/CPHA.
module spi_mnrch_gen #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_mnrch_gen_if.master   bus
);
    localparam int P     = 2 ** DIV_W;
    localparam int H     = P / 2;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [DIV_W-1:0]  D_LEAD   = DIV_W'(H - 1);
    localparam logic [DIV_W-1:0]  D_HALF   = DIV_W'(H);
    localparam logic [DIV_W-1:0]  D_LAST   = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [NUM_SS-1:0] SS_ONE   = NUM_SS'(1);

    typedef enum logic [1:0] {
        IDLE,
        TRANSACT,
        BACKPORCH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [NUM_SS-1:0] ss_n;
    logic              held;
    logic              cpol;
    logic              cpha;
    logic              done_q;
    logic              sel_ok;
    logic              accept;
    logic              lead;
    logic              trail;
    logic              complete;
    logic              cap;
    logic              shift;

    assign sel_ok = 32'(bus.ss_sel) < NUM_SS;

    // Next state plus the per-cycle strobes derived from the divider phase
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        lead      = 1'b0;
        trail     = 1'b0;
        complete  = 1'b0;
        cap       = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                accept = bus.snd && sel_ok;
                if (accept) state_nxt = TRANSACT;
            end
            TRANSACT: begin
                lead  = (div == D_LEAD);
                trail = (div == D_LAST);
                if (trail && bit_cnt == CNT_LAST) state_nxt = BACKPORCH;
            end
            BACKPORCH: begin
                complete = (div == D_LEAD);
                if (complete) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (cpha) begin
            // sample just after each trailing edge; first leading edge only drives
            cap   = (state != IDLE) && (div == '0) && (bit_cnt != '0);
            shift = (lead && bit_cnt != '0) || complete;
        end else begin
            // sample just after each leading edge, shift on the trailing edge
            cap   = (state == TRANSACT) && (div == D_HALF);
            shift = trail;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Free-running SCLK divider, parked at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      div <= '0;
        else if (state == IDLE || complete) div <= '0;
        else                             div <= div + 1'b1;
    end

    // Counts trailing SCLK edges; bounds the data phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      bit_cnt <= '0;
        else if (accept) bit_cnt <= '0;
        else if (trail)  bit_cnt <= bit_cnt + 1'b1;
    end

    // Load word and mode on accept, then shift MSB out / received bit in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cpol      <= 1'b0;
            cpha      <= 1'b0;
        end else if (accept) begin
            shift_reg <= bus.cmd;
            cpol      <= bus.mode[1];
            cpha      <= bus.mode[0];
        end else if (shift) begin
            shift_reg <= {shift_reg[DATA_W-2:0], held};
        end
    end

    // One-bit MISO holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   held <= 1'b0;
        else if (cap) held <= bus.MISO;
    end

    // Slave select and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n   <= '1;
            done_q <= 1'b0;
        end else if (accept) begin
            ss_n   <= ~(SS_ONE << bus.ss_sel);
            done_q <= 1'b0;
        end else if (complete) begin
            ss_n   <= '1;
            done_q <= 1'b1;
        end
    end

    assign bus.SCLK = (div[DIV_W-1] & (state != IDLE)) ^ cpol;
    assign bus.MOSI = shift_reg[DATA_W-1];
    assign bus.SS_n = ss_n;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.resp = shift_reg;
endmodule

// File: tb/tb_spi_mnrch_gen.sv
// tb_spi_mnrch_gen: scoreboard bench with behavioural SPI slaves for a
// 16-bit/2-slave instance and an 8-bit/1-slave/fast-divider instance.
module tb_spi_mnrch_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_mnrch_gen_if #(.DATA_W(16), .NUM_SS(2)) bus16 ();
    spi_mnrch_gen_if #(.DATA_W(8), .NUM_SS(1)) bus8 ();

    spi_mnrch_gen #(.DATA_W(16), .DIV_W(5), .NUM_SS(2)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    spi_mnrch_gen #(.DATA_W(8), .DIV_W(3), .NUM_SS(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    typedef struct {
        logic [31:0] resp;
        logic [31:0] rx;
        int          lat;
        logic [31:0] ss;
        logic        cpol;
    } exp_t;

    typedef struct {
        logic        act;
        logic        prev;
        logic        miso;
        logic [31:0] tx;
        logic [31:0] rx;
        int          pulses;
    } slv_t;

    exp_t        q16[$];
    exp_t        q8[$];
    slv_t        s16 = '{default: '0};
    slv_t        s8 = '{default: '0};
    logic [1:0]  slv_mode16 = 2'b00;
    logic [1:0]  slv_mode8 = 2'b00;
    logic [31:0] slv_tx16 = '0;
    logic [31:0] slv_tx8 = '0;
    logic        b2b = 1'b0;
    int          acc16 = 0, dn16 = 0, acc_cnt16 = 0;
    int          acc8 = 0;
    logic        bsy16_q = 1'b0, dn16_q = 1'b0;
    logic        bsy8_q = 1'b0, dn8_q = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion", nm);
    endtask

    // Completion latency from the SPI timing rules: W periods plus back porch
    function automatic int ref_lat(input int w, input int dw);
        return w * (1 << dw) + (1 << dw) / 2;
    endfunction

    // Behavioural SPI slave, evaluated on sampled SCLK transitions
    function automatic slv_t slv_step(input slv_t s, input logic ss_low, input logic sclk,
                                      input logic mosi, input logic [1:0] md, input int w,
                                      input logic [31:0] txw);
        slv_t n;
        logic ld;
        n = s;
        if (!ss_low) begin
            n.act = 1'b0;
            return n;
        end
        if (!s.act) begin
            n.act    = 1'b1;
            n.prev   = sclk;
            n.tx     = txw;
            n.rx     = '0;
            n.pulses = 0;
            if (!md[0]) n.miso = txw[w-1];
            return n;
        end
        if (sclk != s.prev) begin
            n.prev = sclk;
            ld = (sclk != md[1]);
            if (ld) n.pulses = s.pulses + 1;
            if (ld ^ md[0]) begin
                n.rx = {s.rx[30:0], mosi};
            end else if (md[0]) begin
                n.miso = s.tx[w-1];
                n.tx   = s.tx << 1;
            end else begin
                n.tx   = s.tx << 1;
                n.miso = n.tx[w-1];
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        s16 = slv_step(s16, bus16.SS_n != 2'b11, bus16.SCLK, bus16.MOSI, slv_mode16, 16, slv_tx16);
        bus16.MISO = s16.miso;
        s8 = slv_step(s8, bus8.SS_n != 1'b1, bus8.SCLK, bus8.MOSI, slv_mode8, 8, slv_tx8);
        bus8.MISO = s8.miso;
    end

    // Monitor for the 16-bit instance: accept and completion events
    always @(negedge clk) begin
        exp_t e;
        if (bus16.busy && !bsy16_q) begin
            acc16 = cyc;
            acc_cnt16++;
            chk("accept_done_low16", 32'(bus16.done), 32'd0);
            if (q16.size() > 0) chk("accept_ss16", 32'(bus16.SS_n), q16[0].ss);
            else fail("spurious_accept16");
            if (b2b) chk("b2b_gap16", cyc - dn16, 32'd1);
        end
        if (bus16.done && !dn16_q) begin
            dn16 = cyc;
            if (q16.size() == 0) begin
                fail("unexpected_done16");
            end else begin
                e = q16.pop_front();
                chk("resp16", 32'(bus16.resp), e.resp);
                chk("mosi_stream16", s16.rx, e.rx);
                chk("latency16", cyc - acc16, e.lat);
                chk("pulses16", s16.pulses, 32'd16);
                chk("ss_idle16", 32'(bus16.SS_n), 32'h3);
                chk("sclk_idle16", 32'(bus16.SCLK), 32'(e.cpol));
                chk("busy_off16", 32'(bus16.busy), 32'd0);
            end
        end
        bsy16_q = bus16.busy;
        dn16_q  = bus16.done;
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (bus8.busy && !bsy8_q) begin
            acc8 = cyc;
            chk("accept_done_low8", 32'(bus8.done), 32'd0);
            if (q8.size() > 0) chk("accept_ss8", 32'(bus8.SS_n), q8[0].ss);
            else fail("spurious_accept8");
        end
        if (bus8.done && !dn8_q) begin
            if (q8.size() == 0) begin
                fail("unexpected_done8");
            end else begin
                e = q8.pop_front();
                chk("resp8", 32'(bus8.resp), e.resp);
                chk("mosi_stream8", s8.rx, e.rx);
                chk("latency8", cyc - acc8, e.lat);
                chk("pulses8", s8.pulses, 32'd8);
                chk("ss_idle8", 32'(bus8.SS_n), 32'h1);
                chk("sclk_idle8", 32'(bus8.SCLK), 32'(e.cpol));
            end
        end
        bsy8_q = bus8.busy;
        dn8_q  = bus8.done;
    end

    task automatic wait_idle16();
        int n = 0;
        @(negedge clk);
        while (bus16.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("idle_timeout16");
    endtask

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (bus8.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("idle_timeout8");
    endtask

    task automatic start16(input logic [15:0] c, input logic [1:0] m,
                           input logic s, input logic [15:0] sw);
        wait_idle16();
        slv_mode16 = m;
        slv_tx16   = 32'(sw);
        q16.push_back('{resp: 32'(sw), rx: 32'(c), lat: ref_lat(16, 5),
                        ss: ~(32'd1 << s) & 32'h3, cpol: m[1]});
        bus16.cmd    = c;
        bus16.mode   = m;
        bus16.ss_sel = s;
        bus16.snd    = 1'b1;
        @(negedge clk);
        bus16.snd    = 1'b0;
        bus16.cmd    = 16'($urandom);
        bus16.mode   = 2'($urandom);
        bus16.ss_sel = 1'($urandom);
    endtask

    task automatic start8(input logic [7:0] c, input logic [1:0] m, input logic [7:0] sw);
        wait_idle8();
        slv_mode8 = m;
        slv_tx8   = 32'(sw);
        q8.push_back('{resp: 32'(sw), rx: 32'(c), lat: ref_lat(8, 3),
                       ss: 32'h0, cpol: m[1]});
        bus8.cmd    = c;
        bus8.mode   = m;
        bus8.ss_sel = 1'b0;
        bus8.snd    = 1'b1;
        @(negedge clk);
        bus8.snd  = 1'b0;
        bus8.cmd  = 8'($urandom);
        bus8.mode = 2'($urandom);
    endtask

    task automatic wait_acc16(input int target);
        int n = 0;
        while (acc_cnt16 < target && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail("accept_timeout16");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        bus16.snd = 1'b0; bus16.cmd = '0; bus16.ss_sel = '0; bus16.mode = '0;
        bus8.snd = 1'b0;  bus8.cmd = '0;  bus8.ss_sel = '0;  bus8.mode = '0;
        repeat (3) @(negedge clk);
        chk("rst_ss16", 32'(bus16.SS_n), 32'h3);
        chk("rst_sclk16", 32'(bus16.SCLK), 32'd0);
        chk("rst_busy16", 32'(bus16.busy), 32'd0);
        chk("rst_done16", 32'(bus16.done), 32'd0);
        chk("rst_ss8", 32'(bus8.SS_n), 32'h1);
        chk("rst_done8", 32'(bus8.done), 32'd0);
        rst_n = 1'b1;

        start16(16'hA5C3, 2'b00, 1'b0, 16'h3C5A);
        wait_idle16();
        start16(16'hA5C3, 2'b11, 1'b1, 16'h3C5A);
        wait_idle16();

        start16(16'h5A0F, 2'b00, 1'b1, 16'hC0DE);
        repeat (99) @(negedge clk);
        bus16.cmd = 16'h1234; bus16.ss_sel = 1'b0; bus16.snd = 1'b1;
        repeat (5) @(negedge clk);
        bus16.snd = 1'b0;
        wait_idle16();

        start16(16'hFFFF, 2'b10, 1'b0, 16'h8001);
        repeat (299) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ss16", 32'(bus16.SS_n), 32'h3);
        chk("abort_sclk16", 32'(bus16.SCLK), 32'd0);
        chk("abort_done16", 32'(bus16.done), 32'd0);
        chk("abort_busy16", 32'(bus16.busy), 32'd0);
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start16(16'h0F0F, 2'b01, 1'b1, 16'h1357);
        wait_idle16();

        wait_idle16();
        slv_mode16 = 2'b01;
        slv_tx16   = 32'h0000BEEF;
        for (int i = 0; i < 3; i++)
            q16.push_back('{resp: 32'hBEEF, rx: 32'h6D21, lat: ref_lat(16, 5),
                            ss: 32'h1, cpol: 1'b0});
        base = acc_cnt16;
        bus16.cmd = 16'h6D21; bus16.mode = 2'b01; bus16.ss_sel = 1'b1;
        bus16.snd = 1'b1;
        wait_acc16(base + 1);
        b2b = 1'b1;
        wait_acc16(base + 3);
        bus16.snd = 1'b0;
        wait_idle16();
        b2b = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start16(16'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 16'($urandom));
            wait_idle16();
        end

        start8(8'h81, 2'b01, 8'h7E);
        wait_idle8();
        bus8.ss_sel = 1'b1;
        bus8.snd    = 1'b1;
        repeat (10) @(negedge clk);
        chk("bad_sel_busy8", 32'(bus8.busy), 32'd0);
        chk("bad_sel_ss8", 32'(bus8.SS_n), 32'h1);
        chk("bad_sel_done8", 32'(bus8.done), 32'd1);
        bus8.snd    = 1'b0;
        bus8.ss_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start8(8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom));
            wait_idle8();
        end

        repeat (5) @(negedge clk);
        if (q16.size() != 0) fail("pending16");
        if (q8.size() != 0) fail("pending8");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
